// File: rtl/tdm_pkg.sv
// tdm_pkg: scheduler state encoding and ST-bus frame geometry
package tdm_pkg;
  typedef enum logic [1:0] {HUNT, CHECK, LOCK} sched_state_t;
  localparam int C4_PER_BIT = 2;
  localparam int BITS_PER_CHAN = 8;
  function automatic int frame_len(input int channels);
    return channels * C4_PER_BIT * BITS_PER_CHAN;
  endfunction
endpackage

// File: rtl/tdm_frame_sched.sv
// tdm_frame_sched: ST-bus frame lock with flywheel, channel/bit decode and
// per-channel strobes gated by a frame-aligned double-buffered enable mask
module tdm_frame_sched
  import tdm_pkg::*;
#(
  parameter int CHANNELS = 32,
  parameter int LOSS_FRAMES = 2,
  localparam int FRAME_LEN = frame_len(CHANNELS),
  localparam int CW = $clog2(FRAME_LEN),
  localparam int CHW = $clog2(CHANNELS)
) (
  input  logic           c4,
  input  logic           reset_n,
  input  logic           f0,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_chan,
  input  logic           cfg_en,
  input  logic           err_clr,
  output logic           frame_lock,
  output logic [CHW-1:0] chan,
  output logic [2:0]     bit_idx,
  output logic           load_stb,
  output logic           sample_stb,
  output logic           cpu_int,
  output logic           frame_err
);
  sched_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_miss, w_miss_nxt;
  logic [CHANNELS-1:0] r_shadow, r_active, w_shadow_nxt;
  logic r_err, w_set_err, w_last, w_f0, w_lock, w_en;
  assign w_last = r_cnt == CW'(FRAME_LEN - 1);
  assign w_f0 = ~f0;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt + 1'b1;
    w_miss_nxt = r_miss;
    w_set_err = 1'b0;
    case (r_state)
      HUNT: begin
        w_cnt_nxt = '0;
        if (w_f0) w_state_nxt = CHECK;
      end
      CHECK: begin
        if (w_f0) begin
          w_cnt_nxt = '0;
          if (w_last) begin
            w_state_nxt = LOCK;
            w_miss_nxt = '0;
          end
        end else if (w_last) w_state_nxt = HUNT;
      end
      LOCK: begin
        if (w_f0) begin
          w_cnt_nxt = '0;
          if (w_last) w_miss_nxt = '0;
          else begin
            w_set_err = 1'b1;
            w_state_nxt = CHECK;
          end
        end else if (w_last) begin
          // flywheel: the counter wraps on its own, only the miss is recorded
          w_set_err = 1'b1;
          w_miss_nxt = r_miss + 3'd1;
          if (w_miss_nxt == 3'(LOSS_FRAMES)) w_state_nxt = HUNT;
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (cfg_we) w_shadow_nxt[cfg_chan] = cfg_en;
  end
  always_ff @(posedge c4 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= HUNT;
      r_cnt <= '0;
      r_miss <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_miss <= w_miss_nxt;
      r_shadow <= w_shadow_nxt;
      if (w_last) r_active <= w_shadow_nxt;
      r_err <= w_set_err ? 1'b1 : err_clr ? 1'b0 : r_err;
    end
  end
  assign w_lock = r_state == LOCK;
  assign w_en = w_lock & r_active[r_cnt[CW-1:4]];
  assign frame_lock = w_lock;
  assign chan = r_cnt[CW-1:4];
  assign bit_idx = r_cnt[3:1];
  assign load_stb = w_en & (r_cnt[3:0] == 4'd0);
  assign sample_stb = w_en & r_cnt[0];
  assign cpu_int = w_lock & w_last;
  assign frame_err = r_err;
endmodule
